pixel_word_packer: RTL and testbench

// Upstream neighbour of the frame FIFO: packs a clk_pixel-domain stream of PIXEL_WIDTH-bit pixels

---
 rtl/pixel_stream_pkg.sv | 22 ++
 rtl/pixel_word_packer.sv | 118 +++++++++++
 tb/tb_pixel_word_packer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream path.
//   PIXEL_WIDTH      bits per pixel (RGB565)
//   DATA_WIDTH       bits per packed FIFO word
//   WORDS_PER_FRAME  packed words per frame (matches the frame FIFO depth)
//   PPW              pixels per packed word
//   packer_state_t   word packer frame-alignment state
package pixel_stream_pkg;

  localparam int PIXEL_WIDTH     = 16;
  localparam int DATA_WIDTH      = 256;
  localparam int WORDS_PER_FRAME = 144;
  localparam int PPW             = DATA_WIDTH / PIXEL_WIDTH;

  localparam int SLOT_W = $clog2(PPW);
  localparam int WCNT_W = $clog2(WORDS_PER_FRAME);

  typedef enum logic {
    WAIT_SOF,
    PACK
  } packer_state_t;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs a stream of PIXEL_WIDTH-bit pixels into DATA_WIDTH-bit words for the
// frame FIFO. Packing starts only at a start-of-frame pixel; the last word of
// each frame is flagged. A single output register absorbs FIFO backpressure.
// Ports:
//   clk_pixel         pixel clock, all logic on posedge
//   rst_in            asynchronous active-low reset
//   pixel_valid_in    pixel_data_in valid this cycle
//   pixel_sof_in      pixel is the first pixel of a frame
//   pixel_data_in     pixel value
//   pixel_ready_out   packer accepts the pixel this cycle
//   fifo_ready_in     FIFO accepts the output word this cycle
//   sender_valid_out  output word valid
//   sender_data_out   packed word, pixel 0 in the least significant bits
//   sender_last_out   final word of the frame
//   frame_err_out     one-cycle pulse: SOF arrived in the middle of a frame
module pixel_word_packer
  import pixel_stream_pkg::*;
(
  input  logic                   clk_pixel,
  input  logic                   rst_in,
  input  logic                   pixel_valid_in,
  input  logic                   pixel_sof_in,
  input  logic [PIXEL_WIDTH-1:0] pixel_data_in,
  output logic                   pixel_ready_out,
  input  logic                   fifo_ready_in,
  output logic                   sender_valid_out,
  output logic [DATA_WIDTH-1:0]  sender_data_out,
  output logic                   sender_last_out,
  output logic                   frame_err_out
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_FRAME - 1);

  packer_state_t          state;
  logic [SLOT_W-1:0]      slot;
  logic [WCNT_W-1:0]      word_cnt;
  logic [DATA_WIDTH-1:0]  accumulator;

  logic                   pixel_accept;
  logic                   out_xfer;
  logic [DATA_WIDTH-1:0]  acc_with_pixel;
  logic [DATA_WIDTH-1:0]  sof_word;

  // Only the word-completing pixel has to wait for the output register; it
  // may proceed in the same cycle the FIFO takes the old word.
  assign pixel_ready_out = (state == WAIT_SOF) || (slot != LAST_SLOT) ||
                           !sender_valid_out   || fifo_ready_in;

  assign pixel_accept = pixel_valid_in && pixel_ready_out;
  assign out_xfer     = sender_valid_out && fifo_ready_in;

  // NOTE: every signal assigned in always_comb gets a full default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_with_pixel = accumulator;
    acc_with_pixel[int'(slot) * PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data_in;
    sof_word = '0;
    sof_word[PIXEL_WIDTH-1:0] = pixel_data_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the wide accumulator and output word are reset too: the packer must
  // come out of reset with an all-zero word and no stale pixels.
  always_ff @(posedge clk_pixel or negedge rst_in) begin
    if (!rst_in) begin
      state            <= WAIT_SOF;
      slot             <= '0;
      word_cnt         <= '0;
      accumulator      <= '0;
      sender_valid_out <= 1'b0;
      sender_data_out  <= '0;
      sender_last_out  <= 1'b0;
      frame_err_out    <= 1'b0;
    end else begin
      frame_err_out <= 1'b0;

      // Word taken by the FIFO; a word loaded below in the same cycle
      // overrides this so there is no bubble.
      if (out_xfer) begin
        sender_valid_out <= 1'b0;
        sender_last_out  <= 1'b0;
      end

      if (pixel_accept) begin
        if (pixel_sof_in) begin
          // Start (or restart) a frame: the partial word and word count are
          // dropped, while any word already in the output register survives.
          accumulator   <= sof_word;
          slot          <= SLOT_W'(1);
          word_cnt      <= '0;
          state         <= PACK;
          frame_err_out <= (state == PACK);
        end else if (state == PACK) begin
          if (slot == LAST_SLOT) begin
            sender_data_out  <= acc_with_pixel;
            sender_valid_out <= 1'b1;
            sender_last_out  <= (word_cnt == LAST_WORD);
            slot             <= '0;
            accumulator      <= '0;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= WAIT_SOF;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else begin
            accumulator <= acc_with_pixel;
            slot        <= slot + 1'b1;
          end
        end
        // Non-SOF pixels in WAIT_SOF are accepted and dropped.
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: directed frame scenarios plus a
// randomized run, with a frame-level reference model feeding a scoreboard.
module tb_pixel_word_packer;
  import pixel_stream_pkg::*;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } exp_word_t;

  logic                   clk_pixel = 1'b0;
  logic                   rst_in;
  logic                   pixel_valid_in;
  logic                   pixel_sof_in;
  logic [PIXEL_WIDTH-1:0] pixel_data_in;
  logic                   pixel_ready_out;
  logic                   fifo_ready_in;
  logic                   sender_valid_out;
  logic [DATA_WIDTH-1:0]  sender_data_out;
  logic                   sender_last_out;
  logic                   frame_err_out;

  pixel_word_packer dut (
    .clk_pixel        (clk_pixel),
    .rst_in           (rst_in),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_sof_in     (pixel_sof_in),
    .pixel_data_in    (pixel_data_in),
    .pixel_ready_out  (pixel_ready_out),
    .fifo_ready_in    (fifo_ready_in),
    .sender_valid_out (sender_valid_out),
    .sender_data_out  (sender_data_out),
    .sender_last_out  (sender_last_out),
    .frame_err_out    (frame_err_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] actual,
                       input logic [DATA_WIDTH-1:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  exp_word_t              sb[$];
  logic [PIXEL_WIDTH-1:0] frame_pix[$];
  logic [DATA_WIDTH-1:0]  word_log[$];
  bit  in_frame      = 1'b0;
  int  frame_words   = 0;
  bit  err_pending   = 1'b0;
  int  expected_errs = 0;

  // A frame is a run of pixels after an SOF; every PPW pixels make one word,
  // and the WORDS_PER_FRAME-th word ends the frame.
  function automatic void model_accept(input logic [PIXEL_WIDTH-1:0] d, input logic sof);
    exp_word_t w;
    if (sof) begin
      if (in_frame) begin
        err_pending = 1'b1;
        expected_errs++;
      end
      in_frame    = 1'b1;
      frame_words = 0;
      frame_pix.delete();
      frame_pix.push_back(d);
    end else if (in_frame) begin
      frame_pix.push_back(d);
      if (frame_pix.size() == PPW) begin
        w.data = '0;
        for (int i = 0; i < PPW; i++) w.data[i*PIXEL_WIDTH +: PIXEL_WIDTH] = frame_pix[i];
        frame_words++;
        w.last = (frame_words == WORDS_PER_FRAME);
        sb.push_back(w);
        frame_pix.delete();
        if (w.last) in_frame = 1'b0;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  bit                    acc_flag     = 1'b0;
  bit                    stalled_prev = 1'b0;
  logic [DATA_WIDTH-1:0] held_data;
  logic                  held_last;
  int words_seen   = 0;
  int lasts_seen   = 0;
  int errs_seen    = 0;
  int stall_cycles = 0;

  // Samples 3 time units after the falling edge: inputs driven on the falling
  // edge have settled and the next rising edge has not happened yet.
  always begin
    exp_word_t e;
    logic      exp_ready;
    @(negedge clk_pixel);
    #3;
    acc_flag = 1'b0;
    if (!rst_in) begin
      check("rst_valid", sender_valid_out, 0);
      check("rst_last", sender_last_out, 0);
      check("rst_err", frame_err_out, 0);
      check("rst_ready", pixel_ready_out, 1);
      sb.delete();
      frame_pix.delete();
      in_frame     = 1'b0;
      frame_words  = 0;
      err_pending  = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      if (err_pending || frame_err_out) check("frame_err", frame_err_out, err_pending);
      if (frame_err_out) errs_seen++;
      err_pending = 1'b0;

      if (stalled_prev) begin
        check("hold_valid", sender_valid_out, 1);
        check("hold_data", sender_data_out, held_data);
        check("hold_last", sender_last_out, held_last);
      end
      stalled_prev = sender_valid_out && !fifo_ready_in;
      held_data    = sender_data_out;
      held_last    = sender_last_out;

      if (pixel_valid_in) begin
        exp_ready = !(in_frame && frame_pix.size() == PPW - 1 &&
                      sender_valid_out && !fifo_ready_in);
        check("pixel_ready", pixel_ready_out, exp_ready);
        if (!pixel_ready_out) stall_cycles++;
      end

      if (sender_valid_out && fifo_ready_in) begin
        check("word_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("word_data", sender_data_out, e.data);
          check("word_last", sender_last_out, e.last);
        end
        words_seen++;
        if (sender_last_out) lasts_seen++;
        word_log.push_back(sender_data_out);
      end

      if (pixel_valid_in && pixel_ready_out) begin
        acc_flag = 1'b1;
        model_accept(pixel_data_in, pixel_sof_in);
      end
    end
  end

  // ---------------- FIFO ready driver ----------------
  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;

  initial begin
    fifo_ready_in = 1'b1;
    forever begin
      @(negedge clk_pixel);
      fifo_ready_in = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // ---------------- pixel driver ----------------
  task automatic send_pixel(input logic [PIXEL_WIDTH-1:0] d, input logic sof);
    int waited = 0;
    @(negedge clk_pixel);
    pixel_valid_in = 1'b1;
    pixel_sof_in   = sof;
    pixel_data_in  = d;
    @(posedge clk_pixel);
    while (!acc_flag && waited < 1000) begin
      @(posedge clk_pixel);
      waited++;
    end
    if (!acc_flag) check("pixel_accept_timeout", acc_flag, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_pixel);
      pixel_valid_in = 1'b0;
      pixel_sof_in   = 1'b0;
    end
  endtask

  // Sends n pixels, the first flagged SOF when sof_first is set. Values are
  // base+index unless random data is requested.
  task automatic send_frame(input int base, input int n, input bit sof_first,
                            input bit rand_data, input bit rand_gaps);
    logic [PIXEL_WIDTH-1:0] d;
    for (int i = 0; i < n; i++) begin
      if (rand_gaps && $urandom_range(0, 1) == 1) idle(1);
      d = rand_data ? PIXEL_WIDTH'($urandom) : PIXEL_WIDTH'(base + i);
      send_pixel(d, sof_first && i == 0);
    end
    idle(1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sender_valid_out) && n < 2000) begin
      @(negedge clk_pixel);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk_pixel);
    rst_in = 1'b0;
    @(negedge clk_pixel);
    rst_in = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w0, l0, e0, s0;
    rst_in         = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_sof_in   = 1'b0;
    pixel_data_in  = '0;
    repeat (3) @(negedge clk_pixel);
    rst_in = 1'b1;

    // 1) One full frame, values = index, FIFO always ready.
    w0 = words_seen; l0 = lasts_seen;
    word_log.delete();
    send_frame(0, PPW * WORDS_PER_FRAME, 1'b1, 1'b0, 1'b0);
    drain();
    check("t1_words", words_seen - w0, WORDS_PER_FRAME);
    check("t1_lasts", lasts_seen - l0, 1);
    if (word_log.size() != 0) begin
      check("t1_word0_lo", word_log[0][PIXEL_WIDTH-1:0], 16'h0000);
      check("t1_word0_hi", word_log[0][DATA_WIDTH-1 -: PIXEL_WIDTH], 16'h000F);
    end
    // Back in WAIT_SOF: a word's worth of non-SOF pixels produces nothing.
    w0 = words_seen;
    send_frame(100, PPW, 1'b0, 1'b0, 1'b0);
    drain();
    check("t1_wait_sof", words_seen - w0, 0);

    // 2) Pixels without SOF right after reset are swallowed.
    pulse_reset();
    w0 = words_seen;
    send_frame(7, 5, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t2_no_valid", sender_valid_out, 0);
    check("t2_words", words_seen - w0, 0);

    // 3) FIFO stalls 40 cycles while word 2 sits in the output register.
    w0 = words_seen; s0 = stall_cycles;
    send_frame(0, 41, 1'b1, 1'b0, 1'b0);
    ready_val = 1'b0;
    fork
      begin
        repeat (40) @(negedge clk_pixel);
        ready_val = 1'b1;
      end
    join_none
    send_frame(41, PPW * WORDS_PER_FRAME - 41, 1'b0, 1'b0, 1'b0);
    drain();
    check("t3_stalled", stall_cycles - s0 > 0, 1);
    check("t3_words", words_seen - w0, WORDS_PER_FRAME);

    // 4) SOF at pixel 37 restarts the frame with one error pulse.
    w0 = words_seen; l0 = lasts_seen; e0 = errs_seen;
    send_frame(0, 37, 1'b1, 1'b0, 1'b0);
    send_frame(1000, PPW * WORDS_PER_FRAME, 1'b1, 1'b0, 1'b0);
    drain();
    check("t4_errs", errs_seen - e0, 1);
    check("t4_lasts", lasts_seen - l0, 1);
    check("t4_words", words_seen - w0, 2 + WORDS_PER_FRAME);

    // 5) Reset while a word is pending: it is lost, next frame is clean.
    ready_val = 1'b0;
    send_frame(0, PPW, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("t5_pending", sender_valid_out, 1);
    pulse_reset();
    ready_val = 1'b1;
    w0 = words_seen; l0 = lasts_seen;
    send_frame(500, PPW * WORDS_PER_FRAME, 1'b1, 1'b0, 1'b0);
    drain();
    check("t5_words", words_seen - w0, WORDS_PER_FRAME);
    check("t5_lasts", lasts_seen - l0, 1);

    // 6) Three random frames with random gaps and random backpressure.
    w0 = words_seen; l0 = lasts_seen; e0 = errs_seen;
    ready_rand = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(0, PPW * WORDS_PER_FRAME, 1'b1, 1'b1, 1'b1);
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    drain();
    check("t6_words", words_seen - w0, 3 * WORDS_PER_FRAME);
    check("t6_lasts", lasts_seen - l0, 3);
    check("t6_errs", errs_seen - e0, 0);

    check("total_errs", errs_seen, expected_errs);
    check("final_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
